// File: rtl/lf_tx_fault_responder.sv
// lf_tx_fault_responder
//   Transmit-side link-fault responder for a 10GBASE-R MAC. It qualifies the
//   2-bit link fault status from the RX path against glitches. It then overrides
//   the MAC XGMII TX stream at inter-frame boundaries:
//     - local fault received  -> Remote Fault ordered sets
//     - remote fault received -> Idle
// Ports:
//   clk, reset                      datapath clock, synchronous active-high reset
//   lf_valid, lf_data[1:0]          link fault status stream (never backpressured)
//   in_xgmii_data/ctrl              MAC TX XGMII word (lane n = bits 8n+7:8n)
//   out_xgmii_data/ctrl             registered XGMII word towards the PCS
//   tx_mode[1:0]                    00 NORMAL, 01 SEND_RF, 10 SEND_IDLE
//   subst_cnt[CNT_W-1:0]            saturating count of substituted output words
module lf_tx_fault_responder #(
    parameter int HOLD  = 4,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             lf_valid,
    input  logic [1:0]       lf_data,
    input  logic [63:0]      in_xgmii_data,
    input  logic [7:0]       in_xgmii_ctrl,
    output logic [63:0]      out_xgmii_data,
    output logic [7:0]       out_xgmii_ctrl,
    output logic [1:0]       tx_mode,
    output logic [CNT_W-1:0] subst_cnt
);

    typedef enum logic [1:0] {
        ST_NORMAL    = 2'b00,
        ST_SEND_RF   = 2'b01,
        ST_SEND_IDLE = 2'b10
    } mode_t;

    localparam logic [7:0]       HOLD_C      = 8'(HOLD);
    localparam logic [1:0]       LF_RESERVED = 2'b11;
    localparam logic [63:0]      RF_DATA     = 64'h0200009C_0200009C;
    localparam logic [7:0]       RF_CTRL     = 8'h11;
    localparam logic [63:0]      IDLE_DATA   = 64'h07070707_07070707;
    localparam logic [7:0]       IDLE_CTRL   = 8'hFF;
    localparam logic [7:0]       START_CHAR  = 8'hFB;
    localparam logic [7:0]       TERM_CHAR   = 8'hFD;
    // Lanes where a /S/ is legal (0 and 4); a start anywhere else is ignored.
    localparam logic [7:0]       START_LANES = 8'b0001_0001;
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

    // True when the word carries a /S/ in a legal lane.
    function automatic logic f_has_start(input logic [63:0] d, input logic [7:0] c);
        return (c[0] && (d[7:0] == START_CHAR)) || (c[4] && (d[39:32] == START_CHAR));
    endfunction

    // Frame state after a word: the last /S/ or /T/ in lane order decides,
    // no delimiter leaves the state unchanged.
    function automatic logic f_frame_after(input logic cur, input logic [63:0] d,
                                           input logic [7:0] c);
        logic f;
        f = cur;
        for (int n = 0; n < 8; n++) begin
            if (c[n] && (d[8*n +: 8] == TERM_CHAR)) begin
                f = 1'b0;
            end else if (c[n] && START_LANES[n] && (d[8*n +: 8] == START_CHAR)) begin
                f = 1'b1;
            end else begin
                f = f;
            end
        end
        return f;
    endfunction

    logic [1:0]       r_cand;
    logic [7:0]       r_hcnt;
    logic [1:0]       r_qual;
    logic             r_in_frame;
    mode_t            r_mode;
    logic [63:0]      r_out_data;
    logic [7:0]       r_out_ctrl;
    logic [CNT_W-1:0] r_subst_cnt;

    logic [1:0]       w_cand_n;
    logic [7:0]       w_hcnt_n;
    logic [1:0]       w_qual_n;
    mode_t            w_pending;
    logic             w_safe;
    mode_t            w_mode_n;
    logic [63:0]      w_data_n;
    logic [7:0]       w_ctrl_n;
    logic [CNT_W-1:0] w_cnt_n;
    logic             w_frame_n;

    // Status qualifier: run length of identical valid samples; qual follows
    // the same edge as the run reaching HOLD so the mode can react one cycle later.
    always_comb begin
        w_cand_n = r_cand;
        w_hcnt_n = r_hcnt;
        if (lf_valid) begin
            if (lf_data == r_cand) begin
                if (r_hcnt < HOLD_C) begin
                    w_hcnt_n = r_hcnt + 8'd1;
                end else begin
                    w_hcnt_n = r_hcnt;
                end
            end else begin
                w_cand_n = lf_data;
                w_hcnt_n = 8'd1;
            end
        end else begin
            w_cand_n = r_cand;
            w_hcnt_n = r_hcnt;
        end
        w_qual_n = r_qual;
        if ((w_hcnt_n == HOLD_C) && (w_cand_n != LF_RESERVED)) begin
            w_qual_n = w_cand_n;
        end else begin
            w_qual_n = r_qual;
        end
    end

    // Mode selection at frame boundaries, output substitution and counter.
    always_comb begin
        case (r_qual)
            2'b01:   w_pending = ST_SEND_RF;
            2'b10:   w_pending = ST_SEND_IDLE;
            default: w_pending = ST_NORMAL;
        endcase
        w_safe    = !r_in_frame && !f_has_start(in_xgmii_data, in_xgmii_ctrl);
        w_frame_n = f_frame_after(r_in_frame, in_xgmii_data, in_xgmii_ctrl);
        if ((w_pending != r_mode) && w_safe) begin
            w_mode_n = w_pending;
        end else begin
            w_mode_n = r_mode;
        end
        case (w_mode_n)
            ST_SEND_RF: begin
                w_data_n = RF_DATA;
                w_ctrl_n = RF_CTRL;
            end
            ST_SEND_IDLE: begin
                w_data_n = IDLE_DATA;
                w_ctrl_n = IDLE_CTRL;
            end
            default: begin
                w_data_n = in_xgmii_data;
                w_ctrl_n = in_xgmii_ctrl;
            end
        endcase
        if ((w_mode_n != ST_NORMAL) && (r_subst_cnt != CNT_MAX)) begin
            w_cnt_n = r_subst_cnt + CNT_ONE;
        end else begin
            w_cnt_n = r_subst_cnt;
        end
    end

    // State and registered outputs; reset forces Idle on the line.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cand      <= 2'b00;
            r_hcnt      <= 8'd0;
            r_qual      <= 2'b00;
            r_in_frame  <= 1'b0;
            r_mode      <= ST_NORMAL;
            r_out_data  <= IDLE_DATA;
            r_out_ctrl  <= IDLE_CTRL;
            r_subst_cnt <= {CNT_W{1'b0}};
        end else begin
            r_cand      <= w_cand_n;
            r_hcnt      <= w_hcnt_n;
            r_qual      <= w_qual_n;
            r_in_frame  <= w_frame_n;
            r_mode      <= w_mode_n;
            r_out_data  <= w_data_n;
            r_out_ctrl  <= w_ctrl_n;
            r_subst_cnt <= w_cnt_n;
        end
    end

    assign out_xgmii_data = r_out_data;
    assign out_xgmii_ctrl = r_out_ctrl;
    assign tx_mode        = r_mode;
    assign subst_cnt      = r_subst_cnt;

endmodule

// File: doc/lf_tx_fault_responder.md
# lf_tx_fault_responder

Transmit-side link-fault responder for the 10GBASE-R MAC datapath. It consumes the 2-bit link fault status that the RX path delivers over Avalon-ST and qualifies it against glitches. It then overrides the MAC's 64-bit XGMII TX stream, per IEEE 802.3 clause 46:
- Local fault received: send Remote Fault ordered sets.
- Remote fault received: send Idle.

It sits between the MAC TX XGMII output and the PCS. Mode changes only take effect on inter-frame boundaries, so no frame is truncated.

## Interface
Parameters:
- HOLD, 4, number of consecutive identical valid status samples required to adopt a new status (legal 1..255)
- CNT_W, 32, width of the substituted-word counter

Ports:
- clk  in  1  datapath clock (156.25 MHz)
- reset  in  1  synchronous, active-high reset
- lf_valid  in  1  Avalon-ST valid for link fault status; the block never backpressures
- lf_data  in  2  link fault status: 00 none, 01 local fault, 10 remote fault, 11 reserved
- in_xgmii_data  in  64  MAC TX XGMII data, lane n in bits 8n+7:8n
- in_xgmii_ctrl  in  8  MAC TX XGMII control, bit n for lane n
- out_xgmii_data  out  64  XGMII data to PCS, registered
- out_xgmii_ctrl  out  8  XGMII control to PCS, registered
- tx_mode  out  2  current mode: 00 NORMAL, 01 SEND_RF, 10 SEND_IDLE
- subst_cnt  out  CNT_W  count of output words substituted, saturating

## Operation
Status qualifier:
- Registers: cand (2 bits), hcnt (8 bits), qual (2 bits).
- On a cycle with lf_valid=1 and lf_data==cand: hcnt increments, saturating at HOLD.
- On a cycle with lf_valid=1 and lf_data!=cand: cand←lf_data, hcnt←1.
- lf_valid=0 cycles are ignored; they neither count nor break a run.
- When hcnt==HOLD and cand!=11: qual←cand. A cand of 11 is never adopted.
- pending mode = qual (00→NORMAL, 01→SEND_RF, 10→SEND_IDLE).

Frame tracker:
- Register in_frame is driven by the input word.
- /S/ = ctrl bit set and byte 0xFB, legal only in lane 0 or lane 4. /T/ = ctrl bit set and byte 0xFD, any lane.
- in_frame after a word: 1 if the word has an /S/ with no /T/ in a higher lane; 0 if the word has a /T/ with no later /S/; otherwise unchanged.
- An /S/ in lanes 1-3 or 5-7 is ignored.

Mode FSM (states NORMAL, SEND_RF, SEND_IDLE):
- A word is boundary-safe when in_frame==0 (value before the word) and the word contains no /S/.
- If pending≠tx_mode and the current input word is boundary-safe: tx_mode←pending, and that same word is output under the new mode.
- Any-to-any transitions are allowed directly, e.g. SEND_RF→SEND_IDLE.
- The frame tracker keeps following the MAC stream in every mode. A MAC frame that starts during a fault mode is fully dropped; NORMAL resumes only after its /T/.

Substitution (applies to the word whose output is being registered):
- NORMAL: pass the input through.
- SEND_RF: data 0x0200009C_0200009C, ctrl 0x11 (sequence /Q/ in lanes 0 and 4, remote fault).
- SEND_IDLE: data 0x07070707_07070707, ctrl 0xFF.
- subst_cnt increments for each word output in SEND_RF or SEND_IDLE; saturates at all-ones.

## Timing
- Data latency: in_xgmii to out_xgmii is exactly 1 clk.
- Status latency: the HOLDth consecutive identical valid sample at cycle t gives qual updated at t+1. The earliest mode change is the input word at t+1 if boundary-safe, visible on the output at t+2.
- Values after reset (held during reset):
  - out_xgmii_data=0x07070707_07070707, out_xgmii_ctrl=0xFF
  - tx_mode=00, subst_cnt=0
  - cand=00, hcnt=0, qual=00, in_frame=0
- Reset asserted mid-frame: the output goes to Idle on the next edge, and in_frame is cleared. If the MAC is still mid-frame when reset is released, the tail of that frame passes through as received, since the block has no state left to suppress it.
- Pending changing again before a boundary arrives: the latest pending value wins; no intermediate mode is entered.
- The mode change and the subst_cnt increment for the first substituted word occur on the same edge.

## Test plan
- Status 01 held on lf_valid for 4 cycles while the MAC idles → tx_mode=01 and output data 0x0200009C0200009C, ctrl 0x11 from the 2nd cycle after the 4th sample; subst_cnt increments by 1 per word.
- Status 01 for 3 samples, then 00, then 01 for 3 samples (HOLD=4) → tx_mode stays 00 and the output mirrors the input.
- Status 10 qualified while a frame is mid-transfer (/S/ already sent, /T/ 5 words later) → all 5 remaining words pass unchanged; the first word after /T/ is Idle 0x0707…07/0xFF and tx_mode=10.
- In SEND_RF, status returns to 00 while the MAC sends a new frame → the whole frame is replaced by RF words; NORMAL starts at the first word after that frame's /T/.
- /T/ in lane 2 and /S/ in lane 4 in the same word, with a fault pending → no switch on that word or until the next /T/.
- Reset asserted in SEND_IDLE with subst_cnt=100 → next cycle tx_mode=00, subst_cnt=0, output Idle; lf_valid gaps between samples do not reset hcnt.
